bp_update_queue: RTL

- In-order queue of in-flight branch predictions, sitting between the fetch-side predictor lookup and the BHT write port.
- Fetch pushes {BHT index, predicted direction} for every fetched conditional branch. Execute resolves branches oldest-first.
- For each resolution the block drives the BHT write port (wr_enable/address_wr/counter_update) and raises a mispredict pulse that squashes all younger queued entries.

---
 rtl/bp_update_queue_pkg.sv | 14 +
 rtl/bp_update_queue_if.sv | 37 +++
 rtl/bp_queue_fifo.sv | 70 +++++++
 rtl/bp_update_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/bp_update_queue_pkg.sv
// Constants and helpers shared by the branch-prediction update queue and the BHT.
package bp_update_queue_pkg;

  localparam int BHT_ADDR_WIDTH  = 6;
  // Queue entry layout: {index[BHT_ADDR_WIDTH-1:0], pred}
  localparam int ENTRY_WIDTH     = BHT_ADDR_WIDTH + 1;
  localparam int QUEUE_DEPTH     = 8;
  localparam int QUEUE_PTR_WIDTH = 3;

  function automatic logic is_mispredict(input logic pred, input logic taken);
    return pred != taken;
  endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// Fetch/execute-facing bus of the update queue, including the BHT write port and status.
interface bp_update_queue_if
  import bp_update_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = BHT_ADDR_WIDTH,
  parameter int PTR_WIDTH  = QUEUE_PTR_WIDTH
) ();

  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_WIDTH-1:0] push_index;
  logic                  push_pred;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic                  flush;
  logic                  bht_wr_enable;
  logic [ADDR_WIDTH-1:0] bht_address_wr;
  logic                  bht_counter_update;
  logic                  mispredict;
  logic [PTR_WIDTH:0]    count;
  logic                  empty;
  logic                  full;
  logic                  underflow_err;

  modport master (
    output push_valid, push_index, push_pred, resolve_valid, resolve_taken, flush,
    input  push_ready, bht_wr_enable, bht_address_wr, bht_counter_update,
           mispredict, count, empty, full, underflow_err
  );

  modport slave (
    input  push_valid, push_index, push_pred, resolve_valid, resolve_taken, flush,
    output push_ready, bht_wr_enable, bht_address_wr, bht_counter_update,
           mispredict, count, empty, full, underflow_err
  );

endinterface

// File: rtl/bp_queue_fifo.sv
// Circular FIFO with push, pop and a clear that overrides both.
module bp_queue_fifo
  import bp_update_queue_pkg::*;
#(
  parameter int WIDTH     = ENTRY_WIDTH,
  parameter int DEPTH     = QUEUE_DEPTH,
  parameter int PTR_WIDTH = QUEUE_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap by natural overflow since DEPTH == 2**PTR_WIDTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/bp_update_queue.sv
// In-order queue of in-flight branch predictions; resolves oldest-first into BHT writes.
module bp_update_queue
  import bp_update_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = BHT_ADDR_WIDTH,
  parameter int DEPTH      = QUEUE_DEPTH,
  parameter int PTR_WIDTH  = QUEUE_PTR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  bp_update_queue_if.slave   bus
);

  localparam int EW = ADDR_WIDTH + 1;

  logic [EW-1:0]         head_entry;
  logic [ADDR_WIDTH-1:0] head_index;
  logic                  head_pred;
  logic                  resolve_fire, squash, clear, push_fire;
  logic                  fifo_empty, fifo_full;
  logic [PTR_WIDTH:0]    fifo_count;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  upd_q, upd_d;
  logic                  misp_q, misp_d;
  logic                  underflow_q, underflow_d;

  assign {head_index, head_pred} = head_entry;
  assign resolve_fire = bus.resolve_valid & ~fifo_empty;
  // A mispredict squashes every younger entry in the same edge as the pop.
  assign squash       = resolve_fire & is_mispredict(head_pred, bus.resolve_taken);
  assign clear        = bus.flush | squash;
  // Pushes alongside a squash or flush are wrong-path: handshaken but dropped.
  assign push_fire    = bus.push_valid & ~fifo_full & ~clear;

  bp_queue_fifo #(
    .WIDTH     (EW),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_fire),
    .pop_i   (resolve_fire),
    .clear_i (clear),
    .wdata_i ({bus.push_index, bus.push_pred}),
    .head_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    wr_en_d     = resolve_fire;
    addr_d      = resolve_fire ? head_index : '0;
    upd_d       = resolve_fire & bus.resolve_taken;
    misp_d      = squash;
    underflow_d = underflow_q | (bus.resolve_valid & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      upd_q       <= 1'b0;
      misp_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      upd_q       <= upd_d;
      misp_q      <= misp_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.push_ready         = ~fifo_full;
  assign bus.bht_wr_enable      = wr_en_q;
  assign bus.bht_address_wr     = addr_q;
  assign bus.bht_counter_update = upd_q;
  assign bus.mispredict         = misp_q;
  assign bus.count              = fifo_count;
  assign bus.empty              = fifo_empty;
  assign bus.full               = fifo_full;
  assign bus.underflow_err      = underflow_q;

endmodule
